// File: rtl/cdr_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdr_pattern_tx
// Purpose  : Serial NRZ test-pattern transmitter for exercising an on-chip
//            ADPLL/CDR. Sends framed bursts: an alternating 1010.. preamble
//            for lock acquisition, then a payload (PRBS7, clock pattern or a
//            repeated user byte). Bit rate = clk / (bit_div + 1).
// Ports    : clk           clock, rising edge
//            rst           synchronous active-high reset
//            i_en          1 = run, 0 = freeze everything (outputs hold)
//            i_start       frame request, accepted only in IDLE with i_en=1
//            i_mode        00/11 PRBS7, 01 clock pattern, 10 user byte
//            i_bit_div     clocks per bit minus 1 (latched at start)
//            i_user_byte   payload byte for mode 10, MSB first (latched)
//            o_tx_data     serial NRZ output, idle low
//            o_bit_strobe  pulse on the first clock of each bit
//            o_busy        high while bits are being sent
//            o_frame_done  pulse in the cycle busy falls
// Options  : CDR_TX_CRC_EN - append CRC-8 (poly 0x07, init 0x00) over the
//            payload bits, MSB first, after the payload.
// Revision : 1.0 - initial release
// ============================================================================
module cdr_pattern_tx #(
  parameter int         DIV_W        = 8,
  parameter int         PREAMBLE_LEN = 16,
  parameter int         FRAME_LEN    = 64,
  parameter logic [6:0] SEED         = 7'h7F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [DIV_W-1:0] i_bit_div,
  input  logic [7:0]       i_user_byte,
  output logic             o_tx_data,
  output logic             o_bit_strobe,
  output logic             o_busy,
  output logic             o_frame_done
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [6:0] c_SEED   = (SEED == 7'h00) ? 7'h01 : SEED;
  localparam int         c_MAXLEN = (PREAMBLE_LEN > FRAME_LEN) ? PREAMBLE_LEN : FRAME_LEN;
  localparam int         c_CNT_W  = $clog2(c_MAXLEN);

  localparam logic [2:0] c_S_IDLE = 3'd0;
  localparam logic [2:0] c_S_PRE  = 3'd1;
  localparam logic [2:0] c_S_PAY  = 3'd2;
`ifdef CDR_TX_CRC_EN
  localparam logic [2:0] c_S_CRC  = 3'd3;
`endif
  localparam logic [2:0] c_S_DONE = 3'd4;

  logic [2:0]         r_state;
  logic [DIV_W-1:0]   r_timer;
  logic [DIV_W-1:0]   r_div;
  logic [c_CNT_W-1:0] r_bitcnt;   // index of the current bit within its state
  logic [1:0]         r_mode;
  logic [7:0]         r_ubyte;
  logic [6:0]         r_lfsr;
  logic               r_tx;
  logic               r_strobe;
  logic               r_busy;
  logic               r_done;

  logic               w_wrap;
  logic [6:0]         w_lfsr_next;
  logic [2:0]         w_nidx3;
  logic               w_pay_next;   // payload bit following the current one
  logic               w_pay_first;  // first payload bit, sent after the preamble

  assign w_wrap      = (r_timer == r_div);
  assign w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
  assign w_nidx3     = r_bitcnt[2:0] + 3'd1;

  always_comb begin
    w_pay_next  = w_lfsr_next[6];
    w_pay_first = r_lfsr[6];
    case (r_mode)
      2'b01: begin
        w_pay_next  = ~w_nidx3[0];
        w_pay_first = 1'b1;
      end
      2'b10: begin
        w_pay_next  = r_ubyte[3'd7 - w_nidx3];
        w_pay_first = r_ubyte[7];
      end
      default: ;
    endcase
  end

`ifdef CDR_TX_CRC_EN
  logic [7:0] r_crc;
  logic [7:0] w_crc_next;
  // Serial CRC-8 step over the bit currently on the line.
  assign w_crc_next = {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ r_tx) ? 8'h07 : 8'h00);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_S_IDLE;
      r_timer  <= '0;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_mode   <= 2'b00;
      r_ubyte  <= 8'h00;
      r_lfsr   <= c_SEED;
      r_tx     <= 1'b0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef CDR_TX_CRC_EN
      r_crc    <= 8'h00;
`endif
    end else if (i_en) begin
      if (r_state == c_S_IDLE) begin
        r_done   <= 1'b0;
        r_strobe <= 1'b0;
        if (i_start) begin
          r_mode   <= i_mode;
          r_div    <= i_bit_div;
          r_ubyte  <= i_user_byte;
          r_lfsr   <= c_SEED;
          r_timer  <= '0;
          r_bitcnt <= '0;
          r_state  <= c_S_PRE;
          r_busy   <= 1'b1;
          r_tx     <= 1'b1;
          r_strobe <= 1'b1;
`ifdef CDR_TX_CRC_EN
          r_crc    <= 8'h00;
`endif
        end
      end else if (r_state == c_S_DONE) begin
        r_state <= c_S_IDLE;
        r_done  <= 1'b0;
      end else if (!w_wrap) begin
        r_timer  <= r_timer + DIV_W'(1);
        r_strobe <= 1'b0;
      end else begin
        // Bit period ends: present the next bit on the following clock.
        r_timer  <= '0;
        r_strobe <= 1'b1;
        r_bitcnt <= r_bitcnt + c_CNT_W'(1);
        case (r_state)
          c_S_PRE: begin
            if (r_bitcnt == c_CNT_W'(PREAMBLE_LEN - 1)) begin
              r_state  <= c_S_PAY;
              r_bitcnt <= '0;
              r_tx     <= w_pay_first;
            end else begin
              r_tx <= r_bitcnt[0];  // next index even -> 1, odd -> 0
            end
          end
          c_S_PAY: begin
            r_lfsr <= w_lfsr_next;
`ifdef CDR_TX_CRC_EN
            r_crc  <= w_crc_next;
            if (r_bitcnt == c_CNT_W'(FRAME_LEN - 1)) begin
              r_state  <= c_S_CRC;
              r_bitcnt <= '0;
              r_tx     <= w_crc_next[7];
            end else begin
              r_tx <= w_pay_next;
            end
`else
            if (r_bitcnt == c_CNT_W'(FRAME_LEN - 1)) begin
              r_state  <= c_S_DONE;
              r_bitcnt <= '0;
              r_busy   <= 1'b0;
              r_tx     <= 1'b0;
              r_strobe <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_tx <= w_pay_next;
            end
`endif
          end
`ifdef CDR_TX_CRC_EN
          c_S_CRC: begin
            r_crc <= {r_crc[6:0], 1'b0};
            if (r_bitcnt == c_CNT_W'(7)) begin
              r_state  <= c_S_DONE;
              r_bitcnt <= '0;
              r_busy   <= 1'b0;
              r_tx     <= 1'b0;
              r_strobe <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_tx <= r_crc[6];
            end
          end
`endif
          default: begin
            // Unreachable encodings recover to IDLE.
            r_state  <= c_S_IDLE;
            r_busy   <= 1'b0;
            r_tx     <= 1'b0;
            r_strobe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_tx_data    = r_tx;
  assign o_bit_strobe = r_strobe;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cdr_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdr_pattern_tx
// Purpose  : Self-checking bench for cdr_pattern_tx. A table of frame
//            configurations is replayed; each frame's bits, bit lengths,
//            busy length and frame_done timing are compared to values derived
//            in the bench. Reset, start-with-en=0 and start-in-DONE are
//            covered by hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdr_pattern_tx;

`ifdef CDR_TX_CRC_EN
  localparam int NB = 16 + 64 + 8;
`else
  localparam int NB = 16 + 64;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic [1:0] mode;
  logic [7:0] bit_div;
  logic [7:0] user_byte;
  logic       tx_data;
  logic       bit_strobe;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  cdr_pattern_tx dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en),
    .i_start      (start),
    .i_mode       (mode),
    .i_bit_div    (bit_div),
    .i_user_byte  (user_byte),
    .o_tx_data    (tx_data),
    .o_bit_strobe (bit_strobe),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] div;
    logic [7:0] ub;
    logic [7:0] pay8;        // first 8 payload bits, hand-computed
    int         g1;          // cycle of a stray start pulse (-1 none)
    int         g2;
    int         div_chg_at;  // cycle where bit_div input is changed (-1 none)
    int         en_from;     // first cycle with en=0 (-1 none)
    int         en_len;
    int         stretch_bit; // frame bit index stretched by en=0
  } vec_t;

  vec_t vt[7];
  logic prbs[0:63];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected frame bit k for a given mode/user byte (CRC bits excluded).
  function automatic logic exp_bit(input int k, input logic [1:0] m, input logic [7:0] ub);
    int j;
    if (k < 16) return (k % 2 == 0);
    j = k - 16;
    case (m)
      2'b01:   return (j % 2 == 0);
      2'b10:   return ub[7 - (j % 8)];
      default: return prbs[j];
    endcase
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    logic       got[0:199];
    int         st[0:199];
    logic       expb[0:NB-1];
    int         nb = 0, nbusy = 0, ndone = 0, done_at = -1, post_busy = 0;
    int         c, len, errs, lerrs, bl, ebl;
    logic [7:0] p8, crc;
    string      tag;

    for (int k = 0; k < 80; k++) expb[k] = exp_bit(k, v.mode, v.ub);
`ifdef CDR_TX_CRC_EN
    crc = 8'h00;
    for (int k = 16; k < 80; k++)
      crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ expb[k]) ? 8'h07 : 8'h00);
    for (int k = 0; k < 8; k++) expb[80 + k] = crc[7 - k];
`else
    crc = 8'h00;
`endif

    @(negedge clk);
    mode = v.mode; bit_div = v.div; user_byte = v.ub; en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (done_at < 0 && c < 3000) begin
      if (busy) nbusy++;
      if (busy && bit_strobe) begin
        if (nb < 200) begin got[nb] = tx_data; st[nb] = c; end
        nb++;
      end
      if (frame_done) begin
        ndone++;
        done_at = c;
        check($sformatf("v%0d_busy_at_done", idx), int'(busy), 0);
      end
      start = (c == v.g1 || c == v.g2);
      if (c == v.div_chg_at) bit_div = 8'd7;
      en = !(v.en_from >= 0 && c >= v.en_from && c < v.en_from + v.en_len);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    en    = 1'b1;
    repeat (3) begin
      if (busy) post_busy++;
      if (frame_done) ndone++;
      @(negedge clk);
    end

    tag = $sformatf("v%0d", idx);
    len = NB * (int'(v.div) + 1) + v.en_len;
    check({tag, "_busy_cycles"}, nbusy, len);
    check({tag, "_done_at"}, done_at, len + 1);
    check({tag, "_done_cnt"}, ndone, 1);
    check({tag, "_post_busy"}, post_busy, 0);
    check({tag, "_strobes"}, nb, NB);

    p8 = 8'h00;
    if (nb >= 24) for (int k = 0; k < 8; k++) p8[7 - k] = got[16 + k];
    check({tag, "_pay8"}, int'(p8), int'(v.pay8));

    errs = 0;
    for (int k = 0; k < NB; k++)
      if (k >= nb || k >= 200 || got[k] !== expb[k]) errs++;
    check({tag, "_bit_errs"}, errs, 0);

    lerrs = 0;
    for (int k = 0; k < nb && k < 200; k++) begin
      bl  = (k + 1 < nb && k + 1 < 200) ? st[k + 1] - st[k] : done_at - st[k];
      ebl = int'(v.div) + 1 + ((k == v.stretch_bit) ? v.en_len : 0);
      if (bl != ebl) lerrs++;
    end
    check({tag, "_bitlen_errs"}, lerrs, 0);
  endtask

  initial begin : main
    int c;

    prbs[0:6] = '{1, 1, 1, 1, 1, 1, 1};
    for (int n = 0; n + 7 < 64; n++) prbs[n + 7] = prbs[n] ^ prbs[n + 1];

    //          mode  div    ub     pay8   g1  g2   dchg en_from en_len stretch
    vt[0] = '{2'd0, 8'd3, 8'h00, 8'hFE, -1, -1,  -1,  -1,  0, -1};
    vt[1] = '{2'd1, 8'd1, 8'h00, 8'hAA, -1, -1,  -1,  -1,  0, -1};
    vt[2] = '{2'd2, 8'd0, 8'hA5, 8'hA5, -1, -1,  -1,  -1,  0, -1};
    vt[3] = '{2'd3, 8'd2, 8'h00, 8'hFE, -1, -1,  -1,  -1,  0, -1};
    vt[4] = '{2'd0, 8'd3, 8'h00, 8'hFE,  5, 100, 10,  -1,  0, -1};
    vt[5] = '{2'd0, 8'd3, 8'h00, 8'hFE, -1, -1,  -1,  74, 10, 18};
    vt[6] = '{2'd2, 8'd1, 8'h00, 8'h00, -1, -1,  -1,  -1,  0, -1};

    rst = 1'b1; en = 1'b1; start = 1'b0; mode = 2'd0; bit_div = 8'd0; user_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx",     int'(tx_data),    0);
    check("reset_busy",   int'(busy),       0);
    check("reset_strobe", int'(bit_strobe), 0);
    check("reset_done",   int'(frame_done), 0);
    rst = 1'b0;

    // start with en=0 must be dropped
    @(negedge clk);
    en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    check("start_en0_busy", int'(busy), 0);
    @(negedge clk);
    check("start_en0_busy_later", int'(busy), 0);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // reset held two cycles in the middle of a frame, then immediate restart
    mode = 2'd0; bit_div = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("midframe_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", int'({tx_data, busy, frame_done, bit_strobe}), 0);
    @(negedge clk);
    check("rst_mid_outputs2", int'({tx_data, busy, frame_done, bit_strobe}), 0);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_first_bit", int'({busy, tx_data, bit_strobe}), 7);
    c = 0;
    while (!frame_done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("restart_done_seen", int'(frame_done), 1);
    check("restart_len", c, NB * 4);

    // start while in DONE must be dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done", int'({busy, frame_done}), 0);
    repeat (3) @(negedge clk);
    check("start_in_done_later", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
